// File: rtl/four_way_tc_sched_if.sv
// Operand/result handshake bundle for the four-way carry-less multiply scheduler.
// The slave side is the scheduler; the master side is the producer and consumer.
interface four_way_tc_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [191:0] a;
    logic [191:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [383:0] c;
    logic         busy;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, busy
    );
endinterface

// File: rtl/four_way_tc_sched.sv
// 192x192 GF(2) multiplier: 16 limb products through one digit-serial 48x48 core,
// each XOR-accumulated at offset 48*(i+j).
module four_way_tc_sched #(
    parameter int unsigned D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    four_way_tc_sched_if.slave   bus_if
);
    localparam int unsigned KMAX = 48 / D - 1;
    localparam int unsigned KW   = (48 / D > 1) ? $clog2(48 / D) : 1;

    generate
        if (!(D == 1 || D == 2 || D == 3 || D == 4 || D == 6 || D == 8 ||
              D == 12 || D == 16 || D == 24 || D == 48)) begin : g_bad_d
            $fatal(1, "four_way_tc_sched: D must divide 48 from the legal set");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t          state_q, state_d;
    logic [191:0]    a_q, a_d;
    logic [191:0]    b_q, b_d;
    logic [383:0]    acc_q, acc_d;
    logic [383:0]    c_q, c_d;
    logic [94:0]     part_q, part_d;
    logic [3:0]      p_q, p_d;
    logic [KW-1:0]   k_q, k_d;

    logic [7:0]      a_base, b_base;
    logic [47:0]     a_limb, b_limb;
    logic [8:0]      off;
    logic [5:0]      sh;

    assign a_base = 8'(p_q[3:2]) * 8'd48;
    assign b_base = 8'(p_q[1:0]) * 8'd48;
    assign a_limb = a_q[a_base +: 48];
    assign b_limb = b_q[b_base +: 48];
    assign off    = 9'd48 * (9'(p_q[3:2]) + 9'(p_q[1:0]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        part_d  = part_q;
        p_d     = p_q;
        k_d     = k_q;
        sh      = '0;
        case (state_q)
            IDLE: begin
                if (bus_if.in_valid) begin
                    a_d     = bus_if.a;
                    b_d     = bus_if.b;
                    acc_d   = '0;
                    part_d  = '0;
                    p_d     = '0;
                    k_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // One digit of D a-bits per cycle; k parks at its limit until ACC clears it.
                for (int unsigned t = 0; t < D; t++) begin
                    sh = 6'(k_q * D + t);
                    if (a_limb[sh]) begin
                        part_d = part_d ^ ({47'b0, b_limb} << sh);
                    end
                end
                if (k_q == KW'(KMAX)) begin
                    state_d = ACC;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ACC: begin
                acc_d  = acc_q ^ ({289'b0, part_q} << off);
                part_d = '0;
                k_d    = '0;
                if (p_q == 4'd15) begin
                    c_d     = acc_d;
                    state_d = DONE;
                end else begin
                    p_d     = p_q + 4'd1;
                    state_d = MUL;
                end
            end
            DONE: begin
                if (bus_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            part_q  <= '0;
            p_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            part_q  <= part_d;
            p_q     <= p_d;
            k_q     <= k_d;
        end
    end

    assign bus_if.in_ready  = (state_q == IDLE);
    assign bus_if.out_valid = (state_q == DONE);
    assign bus_if.busy      = (state_q == MUL) || (state_q == ACC);
    assign bus_if.c         = c_q;
endmodule

// File: tb/tb_four_way_tc_sched.sv
// Self-checking bench for four_way_tc_sched at D=1, 4 and 48 against a
// bit-serial reference carry-less multiply held in a scoreboard queue.
module tb_four_way_tc_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0]   in_valid_v  = '0;
    logic [2:0]   out_ready_v = '0;
    logic [2:0]   in_ready_v, out_valid_v, busy_v;
    logic [191:0] a_v [3];
    logic [191:0] b_v [3];
    logic [383:0] c_v [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [383:0] exp_q [$];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int unsigned DG = (g == 0) ? 1 : ((g == 1) ? 4 : 48);
            four_way_tc_sched_if bus ();
            assign bus.in_valid   = in_valid_v[g];
            assign bus.out_ready  = out_ready_v[g];
            assign bus.a          = a_v[g];
            assign bus.b          = b_v[g];
            assign in_ready_v[g]  = bus.in_ready;
            assign out_valid_v[g] = bus.out_valid;
            assign busy_v[g]      = bus.busy;
            assign c_v[g]         = bus.c;
            four_way_tc_sched #(.D(DG)) u_dut (
                .clk    (clk),
                .rst    (rst),
                .bus_if (bus.slave)
            );
        end
    endgenerate

    function automatic logic [383:0] clmul_ref(input logic [191:0] x, input logic [191:0] y);
        logic [383:0] r;
        r = '0;
        for (int i = 0; i < 192; i++) begin
            if (x[i]) r = r ^ ({192'b0, y} << i);
        end
        return r;
    endfunction

    function automatic logic [191:0] rand192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int lat_of(input int di);
        return (di == 0) ? 16 * 49 : ((di == 1) ? 16 * 13 : 16 * 2);
    endfunction

    // Drives one operand pair, pushes its expected product, and returns the
    // edges-to-out_valid latency plus the c observed when out_valid rose.
    task automatic do_op(input int di, input logic [191:0] aa, input logic [191:0] bb,
                         output int lat, output logic [383:0] got);
        int w;
        w = 0;
        while (!in_ready_v[di] && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        a_v[di] = aa;
        b_v[di] = bb;
        in_valid_v[di] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[di] = 1'b0;
        a_v[di] = rand192();
        b_v[di] = rand192();
        exp_q.push_back(clmul_ref(aa, bb));
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid_v[di]) break;
        end
        got = c_v[di];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready_v !== 3'b111) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 111", in_ready_v);
        end
        n_checks++;
        if (out_valid_v !== 3'b000) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 000", out_valid_v);
        end
        n_checks++;
        if (busy_v !== 3'b000) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 000", busy_v);
        end
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (c_v[g] !== 384'd0) begin
                n_fail++; $display("FAIL reset_c[%0d]: got %h expected 0", g, c_v[g]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [383:0] got, exp;
        out_ready_v[1] = 1'b1;
        do_op(1, 192'd1, 192'd1, lat, got);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== 208) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected 208", lat);
        end
        n_checks++;
        if (got !== exp || got !== 384'd1) begin
            n_fail++; $display("FAIL basic_c: got %h expected %h", got, exp);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
            n_fail++; $display("FAIL basic_release: got out_valid=%b in_ready=%b expected 0/1",
                               out_valid_v[1], in_ready_v[1]);
        end
    endtask

    task automatic test_patterns();
        logic [191:0] ta [4];
        logic [191:0] tb [4];
        logic [383:0] tc [4];
        int lat;
        logic [383:0] got, exp;
        ta[0] = 192'd3;          tb[0] = 192'd3;          tc[0] = 384'd5;
        ta[1] = 192'd1 << 47;    tb[1] = 192'd1 << 48;    tc[1] = 384'd1 << 95;
        ta[2] = 192'd1 << 191;   tb[2] = 192'd1 << 191;   tc[2] = 384'd1 << 382;
        ta[3] = '1;              tb[3] = '1;              tc[3] = {1'b0, 1'b1, {191{2'b01}}};
        out_ready_v[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            do_op(1, ta[n], tb[n], lat, got);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp || got !== tc[n]) begin
                n_fail++; $display("FAIL pattern%0d_c: got %h expected %h", n, got, tc[n]);
            end
            n_checks++;
            if (lat !== 208) begin
                n_fail++; $display("FAIL pattern%0d_latency: got %0d expected 208", n, lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [383:0] got, exp;
        out_ready_v[1] = 1'b0;
        do_op(1, rand192(), rand192(), lat, got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL bp_c: got %h expected %h", got, exp);
        end
        for (int n = 0; n < 10; n++) begin
            in_valid_v[1] = (n % 2 == 0);
            a_v[1] = rand192();
            b_v[1] = rand192();
            @(posedge clk); #1;
            n_checks++;
            if (out_valid_v[1] !== 1'b1 || in_ready_v[1] !== 1'b0 || c_v[1] !== exp) begin
                n_fail++; $display("FAIL bp_hold%0d: got out_valid=%b in_ready=%b c=%h expected 1/0/%h",
                                   n, out_valid_v[1], in_ready_v[1], c_v[1], exp);
            end
        end
        in_valid_v[1] = 1'b0;
        out_ready_v[1] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got out_valid=%b in_ready=%b busy=%b expected 0/1/0",
                               out_valid_v[1], in_ready_v[1], busy_v[1]);
        end
        n_checks++;
        if (c_v[1] !== exp) begin
            n_fail++; $display("FAIL bp_c_kept: got %h expected %h", c_v[1], exp);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [383:0] got, exp;
        out_ready_v[1] = 1'b1;
        a_v[1] = rand192();
        b_v[1] = rand192();
        in_valid_v[1] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        n_checks++;
        if (busy_v[1] !== 1'b1) begin
            n_fail++; $display("FAIL mid_busy: got %b expected 1", busy_v[1]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_ctl: got out_valid=%b busy=%b in_ready=%b expected 0/0/1",
                               out_valid_v[1], busy_v[1], in_ready_v[1]);
        end
        n_checks++;
        if (c_v[1] !== 384'd0) begin
            n_fail++; $display("FAIL mid_reset_c: got %h expected 0", c_v[1]);
        end
        do_op(1, rand192(), rand192(), lat, got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp || lat !== 208) begin
            n_fail++; $display("FAIL mid_after: got %h lat %0d expected %h lat 208", got, lat, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int counts [3];
        int lat;
        logic [383:0] got, exp;
        counts[0] = 30;
        counts[1] = 120;
        counts[2] = 200;
        for (int di = 0; di < 3; di++) begin
            out_ready_v[di] = 1'b1;
            for (int n = 0; n < counts[di]; n++) begin
                do_op(di, rand192(), rand192(), lat, got);
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL rand_d%0d_%0d_c: got %h expected %h", di, n, got, exp);
                end
                n_checks++;
                if (lat !== lat_of(di)) begin
                    n_fail++; $display("FAIL rand_d%0d_%0d_latency: got %0d expected %0d",
                                       di, n, lat, lat_of(di));
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            a_v[g] = '0;
            b_v[g] = '0;
        end
        test_reset();
        test_basic();
        test_patterns();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
